// File: rtl/fft_pkg.sv
// Shared widths and loader FSM encoding for the FFT input path.
package fft_pkg;

    localparam int unsigned FLOAT32_W = 32;
    localparam int unsigned FLOAT18_W = 18;
    localparam int unsigned CPLX18_W  = 2 * FLOAT18_W;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/fft_frame_loader_if.sv
// Complex float32 sample stream from the upstream source into the frame loader.
interface fft_frame_loader_if;
    import fft_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [FLOAT32_W-1:0] in_re;
    logic [FLOAT32_W-1:0] in_im;

    modport master (output in_valid, output in_re, output in_im, input in_ready);
    modport slave  (input in_valid, input in_re, input in_im, output in_ready);

endinterface

// File: rtl/cvt_tag_pipe.sv
// Marks which cycles carry a real sample through the converter pipeline.
module cvt_tag_pipe #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tag_in,
    output logic tag_out,
    output logic empty
);

    logic [DEPTH-1:0] tags_q;
    logic [DEPTH-1:0] tags_d;

    if (DEPTH == 1) begin : g_single
        assign tags_d = tag_in;
    end else begin : g_shift
        assign tags_d = {tags_q[DEPTH-2:0], tag_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    assign tag_out = tags_q[DEPTH-1];
    assign empty   = ~|tags_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Streams one frame of complex float32 samples through the float18 converter and
// writes the packed results into the FFT input buffer at sequential addresses.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 8192,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned CVT_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    fft_frame_loader_if.slave    in_if,
    output logic [FLOAT32_W-1:0] cvt_re,
    output logic [FLOAT32_W-1:0] cvt_im,
    input  logic                 cvt_rdy,
    input  logic [CPLX18_W-1:0]  cvt_result,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [CPLX18_W-1:0]  wr_data,
    output logic [ADDR_W:0]      sample_cnt,
    output logic                 err
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] FrameCnt  = CntW'(FRAME_LEN);
    localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_LEN - 1);

    loader_state_e        state_q, state_d;
    logic [CntW-1:0]      issue_cnt_q;
    logic [CntW-1:0]      sample_cnt_q;
    logic [ADDR_W-1:0]    wr_addr_q;
    logic [CPLX18_W-1:0]  wr_data_q;
    logic                 wr_en_q;
    logic                 err_q;
    logic [FLOAT32_W-1:0] cvt_re_q;
    logic [FLOAT32_W-1:0] cvt_im_q;
    logic                 in_ready;
    logic                 accept;
    logic                 start_ok;
    logic                 tag_out;
    logic                 tag_empty;

    assign accept   = in_if.in_valid & in_ready;
    assign start_ok = start & (state_q == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  if (accept && (issue_cnt_q == FrameLast)) state_d = StDrain;
            StDrain: if ((sample_cnt_q == FrameCnt) && tag_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        in_ready   = (state_q == StLoad) && (issue_cnt_q < FrameCnt);
    end

    assign in_if.in_ready = in_ready;

    // Each accepted sample drops a marker that surfaces when its converted value is due.
    cvt_tag_pipe #(
        .DEPTH (CVT_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (accept),
        .tag_out (tag_out),
        .empty   (tag_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_q  <= '0;
            sample_cnt_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            err_q        <= 1'b0;
            cvt_re_q     <= '0;
            cvt_im_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_ok) begin
                issue_cnt_q  <= '0;
                sample_cnt_q <= '0;
                wr_addr_q    <= '0;
                err_q        <= 1'b0;
            end
            if (accept) begin
                cvt_re_q    <= in_if.in_re;
                cvt_im_q    <= in_if.in_im;
                issue_cnt_q <= issue_cnt_q + CntW'(1);
            end
            // A late converter still gets written; the error flag records it.
            if (tag_out) begin
                wr_en_q      <= 1'b1;
                wr_addr_q    <= sample_cnt_q[ADDR_W-1:0];
                wr_data_q    <= cvt_result;
                sample_cnt_q <= sample_cnt_q + CntW'(1);
                if (!cvt_rdy) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign cvt_re     = cvt_re_q;
    assign cvt_im     = cvt_im_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign sample_cnt = sample_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader against a transaction-level model of the
// frame: a queue of pending buffer writes keyed by the clock edge they are due.
module tb_fft_frame_loader;
    import fft_pkg::*;

    localparam int FRAME_LEN = 8;
    localparam int ADDR_W    = 3;
    localparam int CVT_LAT   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 busy;
    logic                 frame_done;
    logic [FLOAT32_W-1:0] cvt_re;
    logic [FLOAT32_W-1:0] cvt_im;
    logic                 cvt_rdy;
    logic [CPLX18_W-1:0]  cvt_result;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [CPLX18_W-1:0]  wr_data;
    logic [ADDR_W:0]      sample_cnt;
    logic                 err;

    fft_frame_loader_if in_if ();

    fft_frame_loader #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W),
        .CVT_LAT   (CVT_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .in_if      (in_if),
        .cvt_re     (cvt_re),
        .cvt_im     (cvt_im),
        .cvt_rdy    (cvt_rdy),
        .cvt_result (cvt_result),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sample_cnt (sample_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Truncating float32 -> float18 (sign, exponent, top 9 mantissa bits) per lane.
    function automatic logic [CPLX18_W-1:0] to_f18x2(input logic [31:0] re, input logic [31:0] im);
        return {re[31:14], im[31:14]};
    endfunction

    // Converter model: the loader's input register plus two stages here gives the
    // result at the third edge after cvt_re/cvt_im change.
    logic [CPLX18_W-1:0] cvt_s1, cvt_s2;
    always_ff @(posedge clk) begin
        cvt_s1 <= to_f18x2(cvt_re, cvt_im);
        cvt_s2 <= cvt_s1;
    end
    assign cvt_result = cvt_s2;

    typedef struct {
        int                  due;
        logic [ADDR_W-1:0]   addr;
        logic [CPLX18_W-1:0] data;
    } wr_t;

    wr_t pend[$];
    int  cyc;
    int  issued;
    int  last_due;
    bit  active;
    bit  loading;

    logic                 exp_wr_en, exp_busy, exp_in_ready, exp_frame_done, exp_err;
    logic [ADDR_W-1:0]    exp_wr_addr;
    logic [CPLX18_W-1:0]  exp_wr_data;
    logic [ADDR_W:0]      exp_sample_cnt;
    logic [31:0]          exp_cvt_re, exp_cvt_im;

    int vectors;
    int miscompares;

    task automatic model_reset();
        pend.delete();
        issued         = 0;
        last_due       = 1 << 30;
        active         = 1'b0;
        loading        = 1'b0;
        exp_wr_en      = 1'b0;
        exp_busy       = 1'b0;
        exp_in_ready   = 1'b0;
        exp_frame_done = 1'b0;
        exp_err        = 1'b0;
        exp_wr_addr    = '0;
        exp_wr_data    = '0;
        exp_sample_cnt = '0;
        exp_cvt_re     = '0;
        exp_cvt_im     = '0;
    endtask

    // Advance one clock edge in the model, then settle 1ns past the edge.
    task automatic step();
        bit  was_idle;
        bit  hs;
        wr_t w;
        @(posedge clk);
        cyc++;
        was_idle  = !active;
        hs        = exp_in_ready && (in_if.in_valid === 1'b1) && !rst;
        exp_wr_en = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            w = pend.pop_front();
            exp_wr_en   = 1'b1;
            exp_wr_addr = w.addr;
            exp_wr_data = w.data;
            exp_sample_cnt++;
            if (!cvt_rdy) exp_err = 1'b1;
        end
        if (hs) begin
            w.due  = cyc + CVT_LAT;
            w.addr = ADDR_W'(issued);
            w.data = to_f18x2(in_if.in_re, in_if.in_im);
            pend.push_back(w);
            exp_cvt_re = in_if.in_re;
            exp_cvt_im = in_if.in_im;
            issued++;
            if (issued == FRAME_LEN) begin
                loading  = 1'b0;
                last_due = cyc + CVT_LAT;
            end
        end
        if (start && was_idle && !rst) begin
            active         = 1'b1;
            loading        = 1'b1;
            issued         = 0;
            exp_sample_cnt = '0;
            exp_wr_addr    = '0;
            exp_err        = 1'b0;
            last_due       = 1 << 30;
        end
        exp_frame_done = active && (cyc == last_due + 1);
        exp_busy       = active;
        if (active && cyc == last_due + 2) begin
            active   = 1'b0;
            exp_busy = 1'b0;
        end
        exp_in_ready = loading;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cvt_rdy = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_re = '0;
        in_if.in_im = '0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, in_if.in_ready, frame_done, wr_en, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=00000", {busy, in_if.in_ready, frame_done, wr_en, err});
        end
        vectors++;
        if ({wr_addr, wr_data, sample_cnt} !== {exp_wr_addr, exp_wr_data, exp_sample_cnt}) begin
            miscompares++;
            $display("FAIL reset_wr got=%h/%h/%0d want=0", wr_addr, wr_data, sample_cnt);
        end
        vectors++;
        if ({cvt_re, cvt_im} !== {exp_cvt_re, exp_cvt_im}) begin
            miscompares++;
            $display("FAIL reset_cvt got=%h/%h want=0", cvt_re, cvt_im);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int writes = 0;
        int dones  = 0;
        in_if.in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0);
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            step();
            vectors++;
            if ({busy, in_if.in_ready, frame_done} !== {exp_busy, exp_in_ready, exp_frame_done}) begin
                miscompares++;
                $display("FAIL basic_ctrl cyc=%0d got=%b want=%b", cyc,
                         {busy, in_if.in_ready, frame_done}, {exp_busy, exp_in_ready, exp_frame_done});
            end
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_wr_addr, exp_wr_data}) begin
                miscompares++;
                $display("FAIL basic_wr cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc, wr_en, wr_addr,
                         wr_data, exp_wr_en, exp_wr_addr, exp_wr_data);
            end
            vectors++;
            if (sample_cnt !== exp_sample_cnt) begin
                miscompares++;
                $display("FAIL basic_cnt cyc=%0d got=%0d want=%0d", cyc, sample_cnt, exp_sample_cnt);
            end
            if (wr_en === 1'b1) writes++;
            if (frame_done === 1'b1) dones++;
            if (!active) break;
        end
        start = 1'b0;
        in_if.in_valid = 1'b0;
        vectors++;
        if (active) begin
            miscompares++;
            $display("FAIL basic_timeout frame still busy after 40 cycles");
        end
        vectors++;
        if (writes != FRAME_LEN || dones != 1) begin
            miscompares++;
            $display("FAIL basic_count got writes=%0d dones=%0d want %0d/1", writes, dones, FRAME_LEN);
        end
    endtask

    task automatic test_gapped();
        int writes = 0;
        in_if.in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            start = (c == 0);
            in_if.in_valid = (c >= 1) && ((c - 1) % 3 == 0);
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            step();
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_wr_addr, exp_wr_data}) begin
                miscompares++;
                $display("FAIL gap_wr cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc, wr_en, wr_addr,
                         wr_data, exp_wr_en, exp_wr_addr, exp_wr_data);
            end
            vectors++;
            if ({in_if.in_ready, frame_done, cvt_re} !== {exp_in_ready, exp_frame_done, exp_cvt_re}) begin
                miscompares++;
                $display("FAIL gap_ctrl cyc=%0d got=%b%b/%h want=%b%b/%h", cyc, in_if.in_ready,
                         frame_done, cvt_re, exp_in_ready, exp_frame_done, exp_cvt_re);
            end
            if (wr_en === 1'b1) writes++;
            if (!active) break;
        end
        start = 1'b0;
        in_if.in_valid = 1'b0;
        vectors++;
        if (active || writes != FRAME_LEN) begin
            miscompares++;
            $display("FAIL gap_done got writes=%0d busy=%0d want %0d/0", writes, active, FRAME_LEN);
        end
    endtask

    task automatic test_start_while_busy();
        int writes = 0;
        int dones  = 0;
        for (int c = 0; c < 80; c++) begin
            start = (c == 0) || (c == 3) || (c == 5) || exp_frame_done;
            in_if.in_valid = 1'($urandom_range(0, 1));
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            step();
            vectors++;
            if ({wr_en, wr_addr, sample_cnt} !== {exp_wr_en, exp_wr_addr, exp_sample_cnt}) begin
                miscompares++;
                $display("FAIL busy_wr cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d", cyc, wr_en, wr_addr,
                         sample_cnt, exp_wr_en, exp_wr_addr, exp_sample_cnt);
            end
            if (wr_en === 1'b1) writes++;
            if (frame_done === 1'b1) dones++;
            if (c > 0 && !active) break;
        end
        start = 1'b0;
        in_if.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if ({busy, in_if.in_ready, wr_en} !== {exp_busy, exp_in_ready, exp_wr_en}) begin
                miscompares++;
                $display("FAIL busy_idle cyc=%0d got=%b want=%b", cyc, {busy, in_if.in_ready, wr_en},
                         {exp_busy, exp_in_ready, exp_wr_en});
            end
        end
        in_if.in_valid = 1'b0;
        vectors++;
        if (writes != FRAME_LEN || dones != 1) begin
            miscompares++;
            $display("FAIL busy_count got writes=%0d dones=%0d want %0d/1", writes, dones, FRAME_LEN);
        end
    endtask

    task automatic test_reset_mid_frame();
        int writes = 0;
        int dones  = 0;
        in_if.in_valid = 1'b1;
        for (int c = 0; c < 20 && issued < 5; c++) begin
            start = (c == 0);
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            step();
        end
        start = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({busy, in_if.in_ready, frame_done, wr_en, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL rstmid_ctrl got=%b want=00000", {busy, in_if.in_ready, frame_done, wr_en, err});
        end
        vectors++;
        if ({wr_addr, wr_data, sample_cnt, cvt_re} !== {exp_wr_addr, exp_wr_data, exp_sample_cnt,
                                                       exp_cvt_re}) begin
            miscompares++;
            $display("FAIL rstmid_data got=%0d/%h/%0d/%h want=0", wr_addr, wr_data, sample_cnt, cvt_re);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors++;
            if ({wr_en, frame_done, busy} !== {exp_wr_en, exp_frame_done, exp_busy}) begin
                miscompares++;
                $display("FAIL rstmid_quiet cyc=%0d got=%b want=%b", cyc, {wr_en, frame_done, busy},
                         {exp_wr_en, exp_frame_done, exp_busy});
            end
        end
        for (int c = 0; c < 40; c++) begin
            start = (c == 0);
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            step();
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_wr_addr, exp_wr_data}) begin
                miscompares++;
                $display("FAIL rstmid_wr cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc, wr_en, wr_addr,
                         wr_data, exp_wr_en, exp_wr_addr, exp_wr_data);
            end
            if (wr_en === 1'b1) writes++;
            if (frame_done === 1'b1) dones++;
            if (!active) break;
        end
        start = 1'b0;
        in_if.in_valid = 1'b0;
        vectors++;
        if (active || writes != FRAME_LEN || dones != 1) begin
            miscompares++;
            $display("FAIL rstmid_refill got writes=%0d dones=%0d want %0d/1", writes, dones, FRAME_LEN);
        end
    endtask

    task automatic test_stall();
        in_if.in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0);
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            cvt_rdy = !(pend.size() > 0 && pend[0].due == cyc + 1 && pend[0].addr == 2);
            step();
            vectors++;
            if ({wr_en, wr_addr, err} !== {exp_wr_en, exp_wr_addr, exp_err}) begin
                miscompares++;
                $display("FAIL stall_wr cyc=%0d got=%b/%0d err=%b want=%b/%0d err=%b", cyc, wr_en,
                         wr_addr, err, exp_wr_en, exp_wr_addr, exp_err);
            end
            if (!active) break;
        end
        cvt_rdy = 1'b1;
        start = 1'b0;
        vectors++;
        if (err !== 1'b1 || active) begin
            miscompares++;
            $display("FAIL stall_sticky got err=%b busy=%0d want err=1 busy=0", err, active);
        end
        for (int c = 0; c < 40; c++) begin
            start = (c == 0);
            in_if.in_re = $urandom;
            in_if.in_im = $urandom;
            step();
            vectors++;
            if ({wr_en, wr_addr, wr_data, err} !== {exp_wr_en, exp_wr_addr, exp_wr_data, exp_err}) begin
                miscompares++;
                $display("FAIL stall_clear cyc=%0d got=%b/%0d/%h err=%b want=%b/%0d/%h err=%b", cyc,
                         wr_en, wr_addr, wr_data, err, exp_wr_en, exp_wr_addr, exp_wr_data, exp_err);
            end
            if (!active) break;
        end
        start = 1'b0;
        in_if.in_valid = 1'b0;
    endtask

    task automatic test_data_integrity();
        for (int c = 0; c < 100; c++) begin
            start = (c == 0);
            in_if.in_valid = (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            in_if.in_re = (c % 2 == 0) ? 32'hC770_82D7 : $urandom;
            in_if.in_im = (c % 2 == 0) ? 32'hC770_82D7 : $urandom;
            step();
            vectors++;
            if ({cvt_re, cvt_im} !== {exp_cvt_re, exp_cvt_im}) begin
                miscompares++;
                $display("FAIL data_cvt cyc=%0d got=%h/%h want=%h/%h", cyc, cvt_re, cvt_im,
                         exp_cvt_re, exp_cvt_im);
            end
            vectors++;
            if ({wr_en, wr_addr, wr_data} !== {exp_wr_en, exp_wr_addr, exp_wr_data}) begin
                miscompares++;
                $display("FAIL data_wr cyc=%0d got=%b/%0d/%h want=%b/%0d/%h", cyc, wr_en, wr_addr,
                         wr_data, exp_wr_en, exp_wr_addr, exp_wr_data);
            end
            if (!active) break;
        end
        start = 1'b0;
        in_if.in_valid = 1'b0;
        vectors++;
        if (active) begin
            miscompares++;
            $display("FAIL data_timeout frame still busy after 100 cycles");
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_start_while_busy();
        test_reset_mid_frame();
        test_stall();
        test_data_integrity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Sequences one FFT input frame through the float32-to-float18 converter (floatToFloat): accepts complex float32 samples from an upstream valid/ready stream and drives the converter's re/im inputs.
- Tracks each sample through the converter's fixed pipeline latency and writes the packed 36-bit results into the FFT input buffer at sequential addresses.
- Raises frame_done once all FRAME_LEN results are written.
- Sits between the sample source and the FFT core's input RAM.

Parameters:
- FRAME_LEN, 8192, complex samples per frame.
- ADDR_W, 13, buffer address width; FRAME_LEN <= 2**ADDR_W.
- CVT_LAT, 4, converter latency in clk cycles from re/im change to matching result (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to load a frame; ignored unless idle.
- busy  out  1  high from accepted start until frame_done inclusive.
- frame_done  out  1  one-cycle pulse after the last buffer write.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  loader can accept a sample.
- in_re  in  32  IEEE-754 single real part.
- in_im  in  32  IEEE-754 single imaginary part.
- cvt_re  out  32  converter real input.
- cvt_im  out  32  converter imaginary input.
- cvt_rdy  in  1  converter output-valid flag.
- cvt_result  in  36  converter output {re18, im18}.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  36  buffer write data.
- sample_cnt  out  ADDR_W+1  results written in the current frame.
- err  out  1  sticky: a tracked sample emerged while cvt_rdy was low.

Behaviour:
- Reset: all outputs 0; state IDLE; tag pipe cleared; counters 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 -> LOAD; clear issue_cnt, sample_cnt, wr_addr, err.
- LOAD:
  - busy=1; in_ready=1 while issue_cnt < FRAME_LEN.
  - Handshake (in_valid & in_ready at an edge): register cvt_re<=in_re, cvt_im<=in_im; issue_cnt++; push tag=1 into the CVT_LAT-deep tag shift register. Non-handshake cycles push tag=0.
  - cvt_re/cvt_im hold their last value between samples.
  - Transition to DRAIN at the edge where issue_cnt becomes FRAME_LEN; in_ready drops the cycle after the last handshake.
- DRAIN: in_ready=0; tag pipe keeps shifting. When sample_cnt == FRAME_LEN and the tag pipe is empty -> DONE.
- DONE: frame_done=1 for exactly one cycle; busy still 1; -> IDLE.
- Tag exit, tag=1 at the pipe output:
  - Next cycle wr_en=1, wr_addr=sample_cnt (pre-increment), wr_data=cvt_result sampled at that edge; sample_cnt++.
  - If cvt_rdy=0 at that edge, still write and additionally set err.
- Latency: handshake at edge k -> wr_en high in the cycle following edge k+CVT_LAT, i.e. CVT_LAT+1 cycles after the handshake. Throughput is 1 sample/clk.
- wr_en is 0 in all other cycles; wr_addr and wr_data hold their last values.
- wr_addr wraps only through reset or a new frame: it never exceeds FRAME_LEN-1.
- start during LOAD, DRAIN or DONE: ignored, no effect on counters.
- start coincident with the DONE cycle: ignored; a new start is required in IDLE.
- in_valid while not in LOAD: not accepted (in_ready=0).
- rst mid-frame: immediate return to IDLE, in-flight tags discarded, no further writes, no frame_done.
- err is cleared only by rst or an accepted start.

Decomposition:
- Shared package fft_pkg: FLOAT32_W=32, FLOAT18_W=18, CPLX18_W=36, state encoding constants for the loader FSM.
- One natural sub-module: cvt_tag_pipe. It is a CVT_LAT-deep 1-bit shift register with an empty flag (OR-reduce), reset to zero.

Test Plan:
- Bench config FRAME_LEN=8, ADDR_W=3, CVT_LAT=3; model converter = 3-stage delay with cvt_rdy=1.
- Basic frame: start, in_valid held high, 8 samples -> in_ready high 8 cycles; wr_en high 8 consecutive cycles starting 4 cycles after the first handshake; wr_addr 0..7 in order; frame_done pulses once; sample_cnt=8.
- Gapped input: in_valid toggled 1,0,0,1,... -> writes only for accepted samples, addresses contiguous 0..7, each write exactly 4 cycles after its handshake.
- start asserted while busy mid-LOAD -> no counter reset; exactly 8 writes and 1 frame_done.
- rst asserted after the 5th handshake -> all outputs 0 within the same cycle; no wr_en afterwards; frame_done never pulses; next start loads 8 fresh samples at addresses 0..7.
- Converter stall: force cvt_rdy=0 when sample 2 exits -> write still at addr 2, err=1 and stays 1 through frame_done; next start clears err.
- Data integrity: in_re=32'hC770_82D7, in_im=32'hC770_82D7 -> cvt_re/cvt_im equal that value the cycle after the handshake; wr_data equals model result at the same address.
